timing_sequencer: RTL and testbench

Sequence counter and run-control stage directly upstream of data_unit. Holds the start/stop flip-flop S, the interrupt-cycle flip-flop R and the interrupt-enable flip-flop IEN. Produces the one-hot timing signals T0..T(NT-1) that the control unit decodes with the IR opcode. The control unit returns sc_clr at the end of each instruction or interrupt cycle, and hlt when a halt instruction executes.

---
 rtl/timing_sequencer.sv | 90 +++++++++
 tb/tb_timing_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timing_sequencer.sv
// Sequence counter with start/stop (S), interrupt-cycle (R) and interrupt-enable (IEN) flops.
// Latency: state updates on the rising edge, and t decodes combinationally from the registers.
// Backpressure: en=0 freezes sequencing, while start/hlt/ien_set/ien_clr still act.
// Optional SEQ_SINGLE_STEP_EN adds step_mode: an advancing sc_clr also clears S.
module timing_sequencer #(
  parameter int NT  = 8,
  parameter int SCW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           start,
  input  logic           hlt,
  input  logic           sc_clr,
  input  logic           ien_set,
  input  logic           ien_clr,
  input  logic           fgi,
  input  logic           fgo,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic           step_mode,
`endif
  output logic [SCW-1:0] sc,
  output logic [NT-1:0]  t,
  output logic           running,
  output logic           r_flag,
  output logic           ien,
  output logic           wrap_err
);

  logic advance;
  logic step_stop;
  logic intr_done;
  logic intr_take;

  assign advance   = running & en;
`ifdef SEQ_SINGLE_STEP_EN
  assign step_stop = step_mode;
`else
  assign step_stop = 1'b0;
`endif

  // R is raised only after fetch (T0..T2) completes, and it ends on the sc_clr of the interrupt cycle.
  assign intr_done = advance & r_flag & sc_clr;
  assign intr_take = advance & ien & (fgi | fgo) & (sc > SCW'(2)) & ~r_flag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc       <= '0;
      running  <= 1'b0;
      r_flag   <= 1'b0;
      ien      <= 1'b0;
      wrap_err <= 1'b0;
    end else begin
      if (hlt) begin
        sc      <= '0;
        running <= 1'b0;
      end else if (start && !running) begin
        running <= 1'b1;
        sc      <= '0;
      end else if (advance) begin
        if (sc_clr) begin
          sc <= '0;
          if (step_stop) running <= 1'b0;
        end else if (sc == SCW'(NT - 1)) begin
          sc       <= '0;
          wrap_err <= 1'b1;
        end else begin
          sc <= sc + 1'b1;
        end
      end

      if (intr_done)
        r_flag <= 1'b0;
      else if (intr_take)
        r_flag <= 1'b1;

      if (ien_clr || intr_done)
        ien <= 1'b0;
      else if (ien_set)
        ien <= 1'b1;
    end
  end

  always_comb begin
    t = '0;
    for (int i = 0; i < NT; i++)
      t[i] = running && (sc == SCW'(i));
  end

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer: reset, sequencing, wrap, interrupt cycle, freeze, halt, and single-step.
module tb_timing_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       en, start, hlt, sc_clr, ien_set, ien_clr, fgi, fgo;
  logic       step_mode;
  logic [2:0] sc;
  logic [7:0] t;
  logic       running, r_flag, ien, wrap_err;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  timing_sequencer #(.NT(8), .SCW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .start    (start),
    .hlt      (hlt),
    .sc_clr   (sc_clr),
    .ien_set  (ien_set),
    .ien_clr  (ien_clr),
    .fgi      (fgi),
    .fgo      (fgo),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode),
`endif
    .sc       (sc),
    .t        (t),
    .running  (running),
    .r_flag   (r_flag),
    .ien      (ien),
    .wrap_err (wrap_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1; start = 1'b0; hlt = 1'b0; sc_clr = 1'b0;
    ien_set = 1'b0; ien_clr = 1'b0; fgi = 1'b0; fgo = 1'b0; step_mode = 1'b0;
  endtask

  task automatic halt_now();
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #12;
    reset = 1'b1;
    repeat (5) tick();
    check_cnt++;
    if ({sc, t, running, r_flag, ien, wrap_err} !== 15'h0)
      $display("FAIL reset_state: sc=%0d t=%h run=%b r=%b ien=%b werr=%b, required all zero",
               sc, t, running, r_flag, ien, wrap_err);
    else pass_cnt++;
  endtask

  task automatic test_start_hlt_same_cycle();
    start = 1'b1; hlt = 1'b1;
    tick();
    start = 1'b0; hlt = 1'b0;
    check_cnt++;
    if (running !== 1'b0) $display("FAIL start_hlt_collision: running=%b required 0", running);
    else pass_cnt++;
  endtask

  task automatic test_sequence();
    logic [7:0] exp_t [5];
    exp_t[0] = 8'h01; exp_t[1] = 8'h02; exp_t[2] = 8'h04; exp_t[3] = 8'h08; exp_t[4] = 8'h10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_cnt++;
      if (t !== exp_t[i] || sc !== 3'(i))
        $display("FAIL seq_t%0d: t=%h sc=%0d required t=%h sc=%0d", i, t, sc, exp_t[i], i);
      else pass_cnt++;
      if (i == 1) start = 1'b1;
      tick();
      start = 1'b0;
    end
    // The loop stops with sc=5 because the restart pulse at sc=1 was ignored, so go back to sc=4 first.
    halt_now();
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    sc_clr = 1'b1;
    tick();
    sc_clr = 1'b0;
    check_cnt++;
    if (sc !== 3'd0 || t !== 8'h01 || running !== 1'b1)
      $display("FAIL seq_sc_clr: sc=%0d t=%h run=%b required sc=0 t=01 run=1", sc, t, running);
    else pass_cnt++;
    halt_now();
  endtask

  task automatic test_ignored_restart();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    check_cnt++;
    if (sc !== 3'd3) $display("FAIL start_while_running: sc=%0d required 3", sc);
    else pass_cnt++;
    halt_now();
  endtask

  task automatic test_wrap();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_cnt++;
      if (sc !== 3'(i) || wrap_err !== 1'b0)
        $display("FAIL wrap_count%0d: sc=%0d werr=%b required sc=%0d werr=0", i, sc, wrap_err, i);
      else pass_cnt++;
    end
    tick();
    check_cnt++;
    if (sc !== 3'd0 || t !== 8'h01 || wrap_err !== 1'b1)
      $display("FAIL wrap_event: sc=%0d t=%h werr=%b required sc=0 t=01 werr=1", sc, t, wrap_err);
    else pass_cnt++;
    halt_now();
    repeat (2) tick();
    check_cnt++;
    if (wrap_err !== 1'b1) $display("FAIL wrap_sticky: werr=%b required 1", wrap_err);
    else pass_cnt++;
  endtask

  task automatic test_ien_priority();
    en = 1'b0;
    ien_set = 1'b1; ien_clr = 1'b1;
    tick();
    check_cnt++;
    if (ien !== 1'b0) $display("FAIL ien_clr_priority: ien=%b required 0", ien);
    else pass_cnt++;
    ien_clr = 1'b0;
    tick();
    ien_set = 1'b0;
    check_cnt++;
    if (ien !== 1'b1) $display("FAIL ien_set_frozen: ien=%b required 1", ien);
    else pass_cnt++;
    ien_clr = 1'b1; tick(); ien_clr = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_interrupt();
    start = 1'b1; ien_set = 1'b1;
    tick();
    start = 1'b0; ien_set = 1'b0;
    // fgi stays high through fetch and must not raise R before sc=3.
    fgi = 1'b1;
    tick(); tick(); tick();
    check_cnt++;
    if (sc !== 3'd3 || r_flag !== 1'b0 || ien !== 1'b1)
      $display("FAIL intr_no_r_in_fetch: sc=%0d r=%b ien=%b required sc=3 r=0 ien=1", sc, r_flag, ien);
    else pass_cnt++;
    tick();
    fgi = 1'b0;
    check_cnt++;
    if (r_flag !== 1'b1) $display("FAIL intr_r_set: r=%b required 1", r_flag);
    else pass_cnt++;
    repeat (6) tick();
    check_cnt++;
    if (sc !== 3'd2 || r_flag !== 1'b1)
      $display("FAIL intr_r_hold: sc=%0d r=%b required sc=2 r=1", sc, r_flag);
    else pass_cnt++;
    sc_clr = 1'b1; ien_set = 1'b1;
    tick();
    sc_clr = 1'b0; ien_set = 1'b0;
    check_cnt++;
    if (r_flag !== 1'b0 || ien !== 1'b0 || sc !== 3'd0)
      $display("FAIL intr_end: r=%b ien=%b sc=%0d required r=0 ien=0 sc=0", r_flag, ien, sc);
    else pass_cnt++;
    halt_now();
  endtask

  task automatic test_freeze_hlt();
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_cnt++;
      if (sc !== 3'd5 || t !== 8'h20)
        $display("FAIL freeze%0d: sc=%0d t=%h required sc=5 t=20", i, sc, t);
      else pass_cnt++;
    end
    hlt = 1'b1; tick(); hlt = 1'b0;
    check_cnt++;
    if (sc !== 3'd0 || running !== 1'b0 || t !== 8'h00)
      $display("FAIL freeze_hlt: sc=%0d run=%b t=%h required sc=0 run=0 t=00", sc, running, t);
    else pass_cnt++;
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    ien_set = 1'b1; start = 1'b1; tick(); start = 1'b0; ien_set = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #2;
    check_cnt++;
    if ({sc, t, running, r_flag, ien, wrap_err} !== 15'h0)
      $display("FAIL reset_async: sc=%0d t=%h run=%b ien=%b werr=%b required all zero",
               sc, t, running, ien, wrap_err);
    else pass_cnt++;
    reset = 1'b1;
    tick(); tick();
    check_cnt++;
    if (running !== 1'b0 || sc !== 3'd0)
      $display("FAIL reset_needs_start: run=%b sc=%0d required run=0 sc=0", running, sc);
    else pass_cnt++;
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    step_mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    sc_clr = 1'b1; tick(); sc_clr = 1'b0;
    check_cnt++;
    if (running !== 1'b0 || sc !== 3'd0)
      $display("FAIL step_stop: run=%b sc=%0d required run=0 sc=0", running, sc);
    else pass_cnt++;
    start = 1'b1; tick(); start = 1'b0;
    check_cnt++;
    if (running !== 1'b1 || t !== 8'h01)
      $display("FAIL step_resume: run=%b t=%h required run=1 t=01", running, t);
    else pass_cnt++;
    step_mode = 1'b0;
    halt_now();
  endtask
`endif

  initial begin
    test_reset();
    test_start_hlt_same_cycle();
    test_sequence();
    test_ignored_restart();
    test_wrap();
    test_ien_priority();
    test_interrupt();
    test_freeze_hlt();
    test_reset_mid();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
